// File: rtl/vga_pkg.sv
// Shared VGA timing constants, region type and region helper.
// Defaults describe 640x480@60 from a 100 MHz system clock.
package vga_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } region_t;

  // Region of a position along one axis; order is active, front, sync, back.
  function automatic region_t region_of(
    input int unsigned pos,
    input int unsigned act,
    input int unsigned fp,
    input int unsigned sw
  );
    if (pos < act)
      region_of = ACTIVE;
    else if (pos < act + fp)
      region_of = FRONT;
    else if (pos < act + fp + sw)
      region_of = SYNC;
    else
      region_of = BACK;
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Pixel clock-enable divider: ce is high on the terminal count.
// Counting stops while en is low and resumes from the held count.
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic CLK100MHZ,
  input  logic BTNU,
  input  logic en,
  output logic ce
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign ce = en && (cnt == LAST);

  // Divider count 0..DIV-1, wrapping on the terminal count.
  always_ff @(posedge CLK100MHZ) begin
    if (BTNU)
      cnt <= '0;
    else if (ce)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator on a pixel clock-enable.
// Optional colour-bar outputs under macro VGA_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          CLK100MHZ,
  input  logic          BTNU,
  input  logic          en,
  output logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT
                         + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT
                         + V_SYNC + V_BACK;

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

  logic          tick;
  logic          x_wrap;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  region_t       h_reg;
  region_t       v_reg;
  logic          de_n;
  logic          hs_n;
  logic          vs_n;

  clk_en_div #(
    .DIV(CLK_DIV)
  ) u_div (
    .CLK100MHZ(CLK100MHZ),
    .BTNU     (BTNU),
    .en       (en),
    .ce       (tick)
  );

  // Next raster position and the levels that belong to it.
  always_comb begin
    x_wrap = (x == X_LAST);
    nx     = x_wrap ? '0 : x + 1'b1;
    ny     = y;
    if (x_wrap)
      ny = (y == Y_LAST) ? '0 : y + 1'b1;
    h_reg = region_of(32'(nx), H_ACTIVE,
                      H_FRONT, H_SYNC);
    v_reg = region_of(32'(ny), V_ACTIVE,
                      V_FRONT, V_SYNC);
    de_n  = (h_reg == ACTIVE) && (v_reg == ACTIVE);
    hs_n  = (h_reg == SYNC) ? HS_POL : ~HS_POL;
    vs_n  = (v_reg == SYNC) ? VS_POL : ~VS_POL;
  end

  // Raster state and registered outputs, updated on each pixel tick.
  always_ff @(posedge CLK100MHZ) begin
    if (BTNU) begin
      x           <= X_LAST;
      y           <= Y_LAST;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      pix_ce      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (tick) begin
      x           <= nx;
      y           <= ny;
      de          <= de_n;
      hsync       <= hs_n;
      vsync       <= vs_n;
      pix_ce      <= 1'b1;
      line_start  <= (nx == '0);
      frame_start <= (nx == '0) && (ny == '0);
    end else begin
      pix_ce      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic [XW-1:0] bar;

  // Eight equal-width bars across the active line.
  always_comb begin
    bar = nx / XW'(BAR);
  end

  // Colour registers aligned with de; black outside the active area.
  always_ff @(posedge CLK100MHZ) begin
    if (BTNU) begin
      vga_r <= 4'h0;
      vga_g <= 4'h0;
      vga_b <= 4'h0;
    end else if (tick) begin
      vga_r <= de_n ? {4{bar[2]}} : 4'h0;
      vga_g <= de_n ? {4{bar[1]}} : 4'h0;
      vga_b <= de_n ? {4{bar[0]}} : 4'h0;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance plus a minimal-timing one.
// Expected values are hand-derived from the timing parameters.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, en0, rst1, en1;
  logic pce0, hs0, vs0, de0, ls0, fs0;
  logic [9:0] x0, y0;
  logic pce1, hs1, vs1, de1, ls1, fs1;
  logic [3:0] x1, y1;
`ifdef VGA_TEST_PATTERN_EN
  logic [3:0] r0, g0, b0, r1, g1, b1;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  vga_timing_gen u_def (
    .CLK100MHZ  (clk),
    .BTNU       (rst0),
    .en         (en0),
    .pix_ce     (pce0),
    .hsync      (hs0),
    .vsync      (vs0),
    .de         (de0),
    .x          (x0),
    .y          (y0),
    .line_start (ls0),
    .frame_start(fs0)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .vga_r      (r0),
    .vga_g      (g0),
    .vga_b      (b0)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV (1),
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL  (1'b1),
    .VS_POL  (1'b1),
    .XW      (4),
    .YW      (4)
  ) u_min (
    .CLK100MHZ  (clk),
    .BTNU       (rst1),
    .en         (en1),
    .pix_ce     (pce1),
    .hsync      (hs1),
    .vsync      (vs1),
    .de         (de1),
    .x          (x1),
    .y          (y1),
    .line_start (ls1),
    .frame_start(fs1)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .vga_r      (r1),
    .vga_g      (g1),
    .vga_b      (b1)
`endif
  );

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Steps until pix_ce of the default instance; -1 on timeout.
  task automatic wait_pce0(input int lim, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!pce0 && n < lim);
    if (!pce0)
      n = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, fs_cyc, pixels, de_cnt, de_last;
    int hs_cnt, hs_first, hs_last, bad, ls_cyc;
    int ex, ey, px, py, de_tot, fs_cnt, last_fs;
    int bad_ce, bad_seq, bad_hs, bad_vs, bad_ls, bad_per;

    rst0 = 1'b1; en0 = 1'b1;
    rst1 = 1'b1; en1 = 1'b1;
    repeat (5) step();

    chk("rst_x",   int'(x0),   799);
    chk("rst_y",   int'(y0),   524);
    chk("rst_de",  int'(de0),  0);
    chk("rst_hs",  int'(hs0),  1);
    chk("rst_vs",  int'(vs0),  1);
    chk("rst_pce", int'(pce0), 0);
    chk("rst_fs",  int'(fs0),  0);
    chk("rst1_hs", int'(hs1),  0);
    chk("rst1_x",  int'(x1),   6);

    rst0 = 1'b0;
    wait_pce0(10, n);
    fs_cyc = cyc;
    chk("first_lat", n, 4);
    chk("first_x",  int'(x0),  0);
    chk("first_y",  int'(y0),  0);
    chk("first_fs", int'(fs0), 1);
    chk("first_ls", int'(ls0), 1);
    chk("first_de", int'(de0), 1);

    wait_pce0(10, n);
    chk("second_lat", n, 4);
    chk("second_x",  int'(x0),  1);
    chk("second_fs", int'(fs0), 0);

    pixels = 2; de_cnt = 2; de_last = 1;
    hs_cnt = 0; hs_first = -1; hs_last = -1;
    bad = 0; ls_cyc = -1;
    for (int i = 0; i < 4000; i++) begin
      step();
      if ((ls0 || fs0) && !pce0)
        bad++;
      if (pce0) begin
        if (ls0) begin
          ls_cyc = cyc;
          break;
        end
        pixels++;
        if (de0) begin
          de_cnt++;
          de_last = int'(x0);
        end
        if (!hs0) begin
          hs_cnt++;
          if (hs_first < 0)
            hs_first = int'(x0);
          hs_last = int'(x0);
        end
`ifdef VGA_TEST_PATTERN_EN
        if (x0 == 10'd85)
          chk("bar1_rgb", int'({r0, g0, b0}), 'h00F);
        if (x0 == 10'd600)
          chk("bar7_rgb", int'({r0, g0, b0}), 'hFFF);
        if (x0 == 10'd700)
          chk("blank_rgb", int'({r0, g0, b0}), 0);
`endif
      end
    end
    chk("line_period", ls_cyc - fs_cyc, 3200);
    chk("line_pixels", pixels, 800);
    chk("line_de_cnt", de_cnt, 640);
    chk("line_de_last", de_last, 639);
    chk("hs_width", hs_cnt, 96);
    chk("hs_first", hs_first, 656);
    chk("hs_last", hs_last, 751);
    chk("strobe_no_ce", bad, 0);
    chk("line1_y", int'(y0), 1);
    chk("line1_x", int'(x0), 0);

    for (int i = 0; i < 2000; i++) begin
      step();
      if (pce0 && x0 == 10'd300)
        break;
    end
    chk("reach_300", int'(x0), 300);
    en0 = 1'b0;
    bad = 0;
    repeat (100) begin
      step();
      if (pce0 || ls0 || fs0 || x0 != 10'd300 ||
          y0 != 10'd1 || !de0 || !hs0 || !vs0)
        bad++;
    end
    chk("freeze", bad, 0);
    en0 = 1'b1;
    wait_pce0(10, n);
    chk("resume_lat", n, 4);
    chk("resume_x", int'(x0), 301);

    step();
    step();
    rst0 = 1'b1;
    en0  = 1'b0;
    step();
    chk("mrst_de",  int'(de0),  0);
    chk("mrst_hs",  int'(hs0),  1);
    chk("mrst_vs",  int'(vs0),  1);
    chk("mrst_x",   int'(x0),   799);
    chk("mrst_y",   int'(y0),   524);
    chk("mrst_pce", int'(pce0), 0);
    en0 = 1'b1;
    step();
    rst0 = 1'b0;
    wait_pce0(10, n);
    chk("mrst_lat", n, 4);
    chk("mrst_fx",  int'(x0),  0);
    chk("mrst_fy",  int'(y0),  0);
    chk("mrst_fs",  int'(fs0), 1);

    rst1 = 1'b0;
    step();
    chk("min_first_ce", int'(pce1), 1);
    chk("min_first_fs", int'(fs1),  1);
    chk("min_first_x",  int'(x1),   0);
    chk("min_first_y",  int'(y1),   0);
    last_fs = cyc;
    px = 0; py = 0;
    de_tot = 0; fs_cnt = 0;
    bad_ce = 0; bad_seq = 0; bad_hs = 0;
    bad_vs = 0; bad_ls = 0; bad_per = 0;
    for (int i = 0; i < 126; i++) begin
      step();
      ex = (px == 6) ? 0 : px + 1;
      ey = (px == 6) ? ((py == 5) ? 0 : py + 1) : py;
      if (!pce1)
        bad_ce++;
      if (int'(x1) != ex || int'(y1) != ey)
        bad_seq++;
      if (hs1 != (x1 == 4'd5))
        bad_hs++;
      if (vs1 != (y1 == 4'd4))
        bad_vs++;
      if (ls1 != (x1 == 4'd0))
        bad_ls++;
      if (de1)
        de_tot++;
      if (fs1) begin
        fs_cnt++;
        if (cyc - last_fs != 42)
          bad_per++;
        last_fs = cyc;
      end
      px = int'(x1);
      py = int'(y1);
    end
    chk("min_ce_cont", bad_ce, 0);
    chk("min_seq", bad_seq, 0);
    chk("min_hs_x5", bad_hs, 0);
    chk("min_vs_y4", bad_vs, 0);
    chk("min_ls", bad_ls, 0);
    chk("min_de_3fr", de_tot, 36);
    chk("min_fs_cnt", fs_cnt, 3);
    chk("min_period", bad_per, 0);

    for (int i = 0; i < 50; i++) begin
      step();
      if (y1 == 4'd2 && x1 == 4'd1)
        break;
    end
    chk("min_mid_y", int'(y1), 2);
    rst1 = 1'b1;
    step();
    chk("min_rst_de", int'(de1), 0);
    chk("min_rst_hs", int'(hs1), 0);
    chk("min_rst_vs", int'(vs1), 0);
    chk("min_rst_x",  int'(x1),  6);
    chk("min_rst_y",  int'(y1),  5);
    rst1 = 1'b0;
    step();
    chk("min_rel_fs", int'(fs1), 1);
    chk("min_rel_x",  int'(x1),  0);
    chk("min_rel_y",  int'(y1),  0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
